// File: rtl/ltc2344_pkg.sv
// Shared constants, window state type and accumulator sizing for the LTC2344 sample averager.
package ltc2344_pkg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } win_state_e;

    // Sample width plus window growth plus one bit so signed and unsigned sums share one format.
    function automatic int acc_width(input int log2_avg);
        return DATA_W + log2_avg + 1;
    endfunction

endpackage

// File: rtl/ltc2344_chan_accum.sv
// One channel of the averager: extends, accumulates, latches the window mode, then rounds and shifts.
module ltc2344_chan_accum #(
    parameter int DATA_W   = 16,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              first,
    input  logic              last,
    input  logic              mode_in,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] result
);
    import ltc2344_pkg::*;

    localparam int ACC_W = acc_width(LOG2_AVG);
    // Half an LSB of the output; collapses to zero when the window is a single sample.
    localparam logic [ACC_W-1:0] ROUND = (ACC_W'(1) << LOG2_AVG) >> 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             mode_q, mode_d;
    logic             sum_signed_q, sum_signed_d;

    logic             mode_eff;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] rounded;

    always_comb begin
        // NOTE: every always_comb output gets its default first, so no path can infer a latch.
        acc_d        = acc_q;
        sum_d        = sum_q;
        mode_d       = mode_q;
        sum_signed_d = sum_signed_q;

        mode_eff = first ? mode_in : mode_q;
        ext      = mode_eff ? {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample}
                            : {{(ACC_W-DATA_W){1'b0}}, sample};
        acc_next = acc_q + ext;

        if (clear) begin
            acc_d = '0;
        end else if (accept) begin
            mode_d = mode_eff;
            if (last) begin
                // The finished sum moves aside so the next window can start in the EMIT cycle.
                sum_d        = acc_next;
                sum_signed_d = mode_eff;
                acc_d        = '0;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    always_comb begin
        rounded = sum_q + ROUND;
        result  = sum_signed_q ? DATA_W'($signed(rounded) >>> LOG2_AVG)
                               : DATA_W'(rounded >> LOG2_AVG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            sum_q        <= '0;
            mode_q       <= 1'b0;
            sum_signed_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            mode_q       <= mode_d;
            sum_signed_q <= sum_signed_d;
        end
    end

endmodule

// File: rtl/ltc2344_sample_averager.sv
// Averages 2^LOG2_AVG four-channel LTC2344 sample sets and hands the rounded means to the host
// through a one-deep valid/ready output register with a sticky overrun flag.
module ltc2344_sample_averager #(
    parameter  int DATA_W   = 16,
    parameter  int LOG2_AVG = 4,
    localparam int CNT_W    = (LOG2_AVG < 1) ? 1 : LOG2_AVG
) (
    input  logic              serialClock,
    input  logic              resetN,
    input  logic              enable,
    input  logic              dataRdy,
    input  logic [DATA_W-1:0] inData0,
    input  logic [DATA_W-1:0] inData1,
    input  logic [DATA_W-1:0] inData2,
    input  logic [DATA_W-1:0] inData3,
    input  logic [3:0]        signedMode,
    output logic [DATA_W-1:0] avgData0,
    output logic [DATA_W-1:0] avgData1,
    output logic [DATA_W-1:0] avgData2,
    output logic [DATA_W-1:0] avgData3,
    output logic              avgValid,
    input  logic              avgReady,
    output logic [CNT_W-1:0]  windowCount,
    output logic              overrun,
    input  logic              clearOverrun
);
    import ltc2344_pkg::*;

    win_state_e state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0][DATA_W-1:0] avg_q, avg_d;
    logic valid_q, valid_d;
    logic overrun_q, overrun_d;

    logic [NUM_CH-1:0][DATA_W-1:0] in_data;
    logic [NUM_CH-1:0][DATA_W-1:0] result;
    logic accept;
    logic first;
    logic last;

    assign in_data = {inData3, inData2, inData1, inData0};
    assign accept  = dataRdy && enable;
    assign first   = (count_q == '0);
    assign last    = (count_q == CNT_W'((1 << LOG2_AVG) - 1));

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        ltc2344_chan_accum #(
            .DATA_W   (DATA_W),
            .LOG2_AVG (LOG2_AVG)
        ) u_accum (
            .clk     (serialClock),
            .rst_n   (resetN),
            .clear   (!enable),
            .accept  (accept),
            .first   (first),
            .last    (last),
            .mode_in (signedMode[ch]),
            .sample  (in_data[ch]),
            .result  (result[ch])
        );
    end

    always_comb begin
        state_d   = (accept && last) ? EMIT : FILL;
        count_d   = count_q;
        avg_d     = avg_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (!enable) begin
            count_d = '0;
        end else if (accept) begin
            count_d = last ? '0 : count_q + 1'b1;
        end

        if (valid_q && avgReady) begin
            valid_d = 1'b0;
        end
        if (clearOverrun) begin
            overrun_d = 1'b0;
        end

        // A result may only land when the slot is empty or being drained this very cycle.
        if (state_q == EMIT) begin
            if (!valid_q || avgReady) begin
                avg_d   = result;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge serialClock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= FILL;
            count_q   <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign avgData0    = avg_q[0];
    assign avgData1    = avg_q[1];
    assign avgData2    = avg_q[2];
    assign avgData3    = avg_q[3];
    assign avgValid    = valid_q;
    assign windowCount = count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ltc2344_sample_averager.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_ltc2344_sample_averager;

    localparam int LOG2_AVG = 4;
    localparam int N        = 1 << LOG2_AVG;

    logic        serialClock = 1'b0;
    logic        resetN;
    logic        enable;
    logic        dataRdy;
    logic [15:0] inData0, inData1, inData2, inData3;
    logic [3:0]  signedMode;
    logic [15:0] avgData0, avgData1, avgData2, avgData3;
    logic        avgValid;
    logic        avgReady;
    logic [3:0]  windowCount;
    logic        overrun;
    logic        clearOverrun;

    ltc2344_sample_averager #(
        .DATA_W   (16),
        .LOG2_AVG (LOG2_AVG)
    ) dut (
        .serialClock  (serialClock),
        .resetN       (resetN),
        .enable       (enable),
        .dataRdy      (dataRdy),
        .inData0      (inData0),
        .inData1      (inData1),
        .inData2      (inData2),
        .inData3      (inData3),
        .signedMode   (signedMode),
        .avgData0     (avgData0),
        .avgData1     (avgData1),
        .avgData2     (avgData2),
        .avgData3     (avgData3),
        .avgValid     (avgValid),
        .avgReady     (avgReady),
        .windowCount  (windowCount),
        .overrun      (overrun),
        .clearOverrun (clearOverrun)
    );

    always #5 serialClock = ~serialClock;

    typedef struct {
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0]       mode;
        logic [3:0][15:0] expd;
    } vec_t;

    typedef struct {
        int               due;
        logic [3:0][15:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge serialClock);
        #1;
    endtask

    function automatic logic [3:0][15:0] all4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [3:0][15:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                               input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic strobe(input logic [3:0][15:0] v);
        inData0 = v[0];
        inData1 = v[1];
        inData2 = v[2];
        inData3 = v[3];
        dataRdy = 1'b1;
        tick();
        dataRdy = 1'b0;
    endtask

    task automatic send_window(input logic [3:0][15:0] a, input logic [3:0][15:0] b,
                               input logic [3:0] mode);
        signedMode = mode;
        for (int i = 0; i < N; i++) strobe((i % 2 == 0) ? a : b);
    endtask

    task automatic check_out(input string tag, input logic [3:0][15:0] req);
        check({tag, "_d0"}, avgData0, req[0]);
        check({tag, "_d1"}, avgData1, req[1]);
        check({tag, "_d2"}, avgData2, req[2]);
        check({tag, "_d3"}, avgData3, req[3]);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t             vecs[4];
        exp_t             q[$];
        longint           sum[4];
        longint           mean;
        logic [3:0]       wmode;
        logic [3:0][15:0] v;
        logic [3:0][15:0] e;
        logic [15:0]      pick;
        logic             exp_v;
        int               cnt;
        int               cyc;

        vecs[0] = '{a: all4(16'h1000), b: all4(16'h1000), mode: 4'b0000,
                    expd: all4(16'h1000)};
        vecs[1] = '{a: pack4(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000),
                    b: pack4(16'hFFFE, 16'hFFFE, 16'h0002, 16'h0001), mode: 4'b0010,
                    expd: pack4(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0001)};
        vecs[2] = '{a: pack4(16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFF0),
                    b: pack4(16'h8000, 16'h7FFF, 16'h0000, 16'hFFF1), mode: 4'b1111,
                    expd: pack4(16'h8000, 16'h7FFF, 16'h0000, 16'hFFF1)};
        vecs[3] = '{a: pack4(16'h8000, 16'hFFFF, 16'h0003, 16'h0010),
                    b: pack4(16'h8000, 16'hFFFF, 16'h0004, 16'h0011), mode: 4'b0000,
                    expd: pack4(16'h8000, 16'hFFFF, 16'h0004, 16'h0011)};

        enable = 1'b1; dataRdy = 1'b0; avgReady = 1'b1; clearOverrun = 1'b0;
        signedMode = 4'b0000;
        inData0 = '0; inData1 = '0; inData2 = '0; inData3 = '0;
        do_reset();

        check("rst_valid", avgValid, 1'b0);
        check("rst_count", windowCount, 4'd0);
        check("rst_overrun", overrun, 1'b0);
        check_out("rst", all4(16'h0000));

        for (int i = 0; i < 4; i++) begin
            send_window(vecs[i].a, vecs[i].b, vecs[i].mode);
            check($sformatf("vec%0d_valid_early", i), avgValid, 1'b0);
            tick();
            check($sformatf("vec%0d_valid", i), avgValid, 1'b1);
            check_out($sformatf("vec%0d", i), vecs[i].expd);
            check($sformatf("vec%0d_overrun", i), overrun, 1'b0);
            tick();
            check($sformatf("vec%0d_valid_drop", i), avgValid, 1'b0);
        end

        // Mode is taken from the first sample only.
        signedMode = 4'b0001;
        strobe(all4(16'hFFFF));
        signedMode = 4'b0010;
        for (int i = 1; i < N; i++) strobe((i % 2 == 1) ? all4(16'h0001) : all4(16'hFFFF));
        tick();
        check("mode_latch_valid", avgValid, 1'b1);
        check_out("mode_latch", pack4(16'h0000, 16'h8000, 16'h8000, 16'h8000));
        tick();

        // Overrun: second result discarded while the first is held.
        avgReady = 1'b0;
        send_window(all4(16'h0100), all4(16'h0100), 4'b0000);
        tick();
        check("ovr_first_valid", avgValid, 1'b1);
        send_window(all4(16'h0200), all4(16'h0200), 4'b0000);
        tick();
        check("ovr_hold_valid", avgValid, 1'b1);
        check_out("ovr_hold", all4(16'h0100));
        check("ovr_set", overrun, 1'b1);
        avgReady = 1'b1;
        tick();
        avgReady = 1'b0;
        check("ovr_accept_valid", avgValid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        clearOverrun = 1'b1;
        tick();
        clearOverrun = 1'b0;
        check("ovr_clear", overrun, 1'b0);

        // Set beats a simultaneous clear.
        send_window(all4(16'h0300), all4(16'h0300), 4'b0000);
        tick();
        send_window(all4(16'h0400), all4(16'h0400), 4'b0000);
        clearOverrun = 1'b1;
        tick();
        clearOverrun = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        clearOverrun = 1'b1;
        avgReady = 1'b1;
        tick();
        clearOverrun = 1'b0;
        avgReady = 1'b0;

        // Full slot drained in the EMIT cycle takes the new result without overrun.
        send_window(all4(16'h0500), all4(16'h0500), 4'b0000);
        tick();
        send_window(all4(16'h0600), all4(16'h0600), 4'b0000);
        avgReady = 1'b1;
        tick();
        avgReady = 1'b0;
        check("replace_valid", avgValid, 1'b1);
        check_out("replace", all4(16'h0600));
        check("replace_overrun", overrun, 1'b0);
        avgReady = 1'b1;
        tick();
        check("replace_drain", avgValid, 1'b0);

        // Enable low discards the partial window; strobes while disabled are ignored.
        signedMode = 4'b0000;
        for (int i = 0; i < 5; i++) strobe(all4(16'h7777));
        check("en_partial_count", windowCount, 4'd5);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) strobe(all4(16'h7777));
        check("en_cleared_count", windowCount, 4'd0);
        enable = 1'b1;
        send_window(all4(16'h0040), all4(16'h0040), 4'b0000);
        strobe(all4(16'h0050));
        check("emit_strobe_count", windowCount, 4'd1);
        check("en_result_valid", avgValid, 1'b1);
        check_out("en_result", all4(16'h0040));
        for (int i = 1; i < N; i++) strobe(all4(16'h0050));
        check("emit_win_early", avgValid, 1'b0);
        tick();
        check("emit_win_valid", avgValid, 1'b1);
        check_out("emit_win", all4(16'h0050));
        tick();

        // Asynchronous reset mid-window with a pending result and overrun set.
        avgReady = 1'b0;
        send_window(all4(16'h0111), all4(16'h0111), 4'b0000);
        tick();
        send_window(all4(16'h0222), all4(16'h0222), 4'b0000);
        tick();
        check("pre_rst_overrun", overrun, 1'b1);
        for (int i = 0; i < 3; i++) strobe(all4(16'h7777));
        #3;
        resetN = 1'b0;
        #1;
        check("arst_valid", avgValid, 1'b0);
        check("arst_count", windowCount, 4'd0);
        check("arst_overrun", overrun, 1'b0);
        check_out("arst", all4(16'h0000));
        @(posedge serialClock);
        #1;
        resetN = 1'b1;
        avgReady = 1'b1;
        send_window(all4(16'h0123), all4(16'h0123), 4'b0000);
        tick();
        check("post_rst_valid", avgValid, 1'b1);
        check_out("post_rst", all4(16'h0123));
        tick();

        // Randomized run against an arithmetic mean model.
        do_reset();
        avgReady = 1'b1;
        cnt = 0;
        cyc = 0;
        wmode = '0;
        for (int ch = 0; ch < 4; ch++) sum[ch] = 0;
        for (int k = 0; k < 803; k++) begin
            dataRdy = (k < 800) && ($urandom_range(0, 3) != 0);
            signedMode = 4'($urandom);
            for (int ch = 0; ch < 4; ch++) begin
                case ($urandom_range(0, 5))
                    0:       pick = 16'h0000;
                    1:       pick = 16'hFFFF;
                    2:       pick = 16'h8000;
                    3:       pick = 16'h7FFF;
                    default: pick = 16'($urandom);
                endcase
                v[ch] = pick;
            end
            inData0 = v[0]; inData1 = v[1]; inData2 = v[2]; inData3 = v[3];
            if (dataRdy) begin
                if (cnt == 0) wmode = signedMode;
                for (int ch = 0; ch < 4; ch++)
                    sum[ch] += wmode[ch] ? longint'($signed(v[ch])) : longint'(v[ch]);
                cnt++;
                if (cnt == N) begin
                    for (int ch = 0; ch < 4; ch++) begin
                        mean  = floor_div(sum[ch] + N / 2, N);
                        e[ch] = 16'(mean);
                        sum[ch] = 0;
                    end
                    q.push_back('{due: cyc + 2, data: e});
                    cnt = 0;
                end
            end
            tick();
            cyc++;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            check("rand_valid", avgValid, exp_v);
            if (exp_v) begin
                check_out("rand", q[0].data);
                void'(q.pop_front());
            end
        end
        dataRdy = 1'b0;
        check("rand_queue_empty", q.size(), 0);
        check("rand_overrun", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltc2344_sample_averager.md
Name: ltc2344_sample_averager

Overview:
- Downstream stage of the LTC2344 CMOS controller, in the same serialClock domain.
- Consumes the 4-channel 16-bit sample set strobed by dataRdy and accumulates 2^LOG2_AVG sets per channel.
- Emits the rounded per-channel mean through a valid/ready handshake toward the host-side logic (FIFO/UART/AXI bridge).
- Reports dropped windows via a sticky overrun flag.

Parameters:
- DATA_W, 16, sample width per channel. Only 16 is supported; this matches the 16-bit controller build.
- LOG2_AVG, 4, log2 of the window length N. Legal range is 0..8; 0 is passthrough with the same latency.

Ports:
- serialClock  input  1  single clock, shared with the ADC controller
- resetN  input  1  asynchronous active-low reset
- enable  input  1  averaging enabled; low clears the window in progress
- dataRdy  input  1  one-cycle strobe; inData0..3 are valid in the same cycle
- inData0..inData3  input  16 each  channel samples from the controller
- signedMode  input  4  per channel: 1 = two's complement (bipolar SoftSpan), 0 = straight binary
- avgData0..avgData3  output  16 each  rounded channel means
- avgValid  output  1  result available
- avgReady  input  1  consumer accepts the result when avgValid && avgReady
- windowCount  output  LOG2_AVG (min 1)  number of samples accumulated in the current window
- overrun  output  1  sticky: a completed window was discarded
- clearOverrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async assert, sync release): all accumulators, windowCount, avgData0..3, avgValid and overrun go to 0; window FSM to FILL.
- Window FSM has two states, FILL and EMIT.
  - FILL: on dataRdy && enable, each channel adds its sample (sign- or zero-extended per latched mode) to its DATA_W+LOG2_AVG+1 bit accumulator, and windowCount increments.
  - At the first sample of a window (windowCount==0), signedMode is latched per channel and held for the whole window. Changes mid-window are ignored.
  - On the dataRdy that makes the count N, go to EMIT and reload the accumulators/count to 0.
  - EMIT: lasts one cycle. result = (sum + 2^(LOG2_AVG-1)) >>> LOG2_AVG, using an arithmetic shift if signed and a logical shift otherwise; no rounding term when LOG2_AVG=0. Result is truncated to 16 bits. The width guarantees no overflow, so no saturation logic is needed.
  - A dataRdy that arrives during EMIT is accumulated as sample 1 of the next window. It is never lost.
- Latency: final dataRdy in cycle t → EMIT in t+1 → avgValid high and avgData valid in t+2.
- Output register (empty/full):
  - If empty in EMIT: load avgData, set avgValid.
  - If full and the same cycle has avgValid && avgReady: the new result replaces the old and avgValid stays 1.
  - If full and not accepted: the new result is discarded, old data is held, and overrun is set.
- Handshake: avgData is stable while avgValid && !avgReady. avgValid drops the cycle after acceptance unless it is reloaded in the same cycle.
- overrun: clearOverrun clears it. If a set and a clear occur in the same cycle, set wins.
- enable low: the accumulators and windowCount clear the next cycle. A pending output and overrun are untouched. An EMIT already in flight completes.
- A dataRdy while enable is low is ignored.
- Reset mid-window discards the partial sums with no output.

Decomposition:
- Package ltc2344_pkg holds:
  - NUM_CH=4 and DATA_W=16
  - the window state enum {FILL, EMIT}
  - a function for accumulator width (DATA_W+LOG2_AVG+1)
- Sub-module ltc2344_chan_accum, instantiated 4x: extends, accumulates, latches mode, rounds and shifts. The parent owns the FSM, windowCount, output register, handshake and overrun.

Test Plan:
- Unsigned, LOG2_AVG=4, 16 strobes of 0x1000 on all channels, avgReady=1 → avgValid exactly 2 cycles after the 16th strobe, avgData0..3=0x1000, overrun=0.
- Signed ch1, samples alternate 0xFFFF/0xFFFE (−1/−2), sum=−24 → (−24+8)>>>4 = −1 = 0xFFFF. Same pattern unsigned on ch0: (0xFFFF*8+0xFFFE*8+8)>>4 = 0xFFFF.
- Rounding: unsigned alternating 1/2, sum=24 → avgData=0x0002. Alternating 0/1, sum=8 → 0x0001 (round half up).
- Hold avgReady=0 across two full windows (first window 0x0100, second 0x0200) → avgData stays 0x0100 and overrun=1. Then avgReady=1 → accepted, avgValid=0. clearOverrun → overrun=0.
- Drop enable after 5 strobes, then re-enable and send 16 strobes of 0x0040 → windowCount returns to 0 and the result is 0x0040, unpolluted by the earlier samples. dataRdy during EMIT is counted (windowCount=1 after EMIT).
- Assert resetN low asynchronously mid-window with avgValid=1 → all outputs 0 immediately. After release, a full window produces a correct result.
